// File: rtl/datapath_ctrl.sv
// datapath_ctrl: instruction sequencer for a simple 64-bit datapath.
// Accepts one 32-bit instruction per valid/ready handshake, decodes it and
// walks it through IDLE -> DECODE -> EXEC [-> MEM [-> WB]] while driving the
// datapath control word. All outputs are registered (Moore).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   instr        instruction word, captured on instr_valid & instr_ready
//   instr_valid  instruction offered
//   instr_ready  controller idle and able to accept
//   status       ALU flags {V,C,N,Z}
//   mem_ack      memory completion strobe
//   fs, c0       ALU function select / carry-in
//   addrR/A/B    register file write / read-A / read-B addresses
//   k, s         constant word and constant-select for the B operand
//   sb, sd       register-B-to-bus and ALU-to-bus (write data) selects
//   w            register file write enable (never for X31)
//   mem_re/we    memory read / write request, held until mem_ack
//   flags        status captured by the last R/I instruction
//   busy         high in every state other than IDLE
//   err          one-cycle pulse after an illegal opcode
module datapath_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  status,
  input  logic        mem_ack,
  output logic [4:0]  fs,
  output logic [4:0]  addrR,
  output logic [4:0]  addrA,
  output logic [4:0]  addrB,
  output logic [63:0] k,
  output logic        s,
  output logic        sb,
  output logic        sd,
  output logic        c0,
  output logic        w,
  output logic        mem_re,
  output logic        mem_we,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        err
);

  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_EOR  = 11'h650;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [9:0]  OPC_ADDI = 10'h244;
  localparam logic [9:0]  OPC_SUBI = 10'h344;

  localparam logic [4:0]  FS_ADD = 5'h08;
  localparam logic [4:0]  FS_SUB = 5'h09;
  localparam logic [4:0]  FS_AND = 5'h00;
  localparam logic [4:0]  FS_ORR = 5'h04;
  localparam logic [4:0]  FS_EOR = 5'h0C;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {CLS_ILL, CLS_R, CLS_I, CLS_LD, CLS_ST} cls_t;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        err;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        s;
    logic [4:0]  addr_r;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic        sb;
    logic        sd;
    logic        w;
    logic        mem_re;
    logic        mem_we;
  } ctrl_t;

  state_t      state, state_nx;
  logic [31:0] ir;
  cls_t        cls;
  logic [4:0]  dec_fs;
  logic        dec_c0;
  logic [63:0] dec_k;
  ctrl_t       ctrl, ctrl_nx;
  logic        accept;

  logic [4:0]  rd, rn, rm;
  assign rd = ir[4:0];   // Rd for R/I, Rt for D-format
  assign rn = ir[9:5];
  assign rm = ir[20:16];

  assign accept = (state == IDLE) && instr_valid && ctrl.ready;

  // Instruction class, ALU function and constant from the captured word.
  always_comb begin
    cls    = CLS_ILL;
    dec_fs = '0;
    dec_c0 = 1'b0;
    dec_k  = '0;
    case (ir[31:21])
      OPC_ADD:  begin cls = CLS_R;  dec_fs = FS_ADD; end
      OPC_SUB:  begin cls = CLS_R;  dec_fs = FS_SUB; dec_c0 = 1'b1; end
      OPC_AND:  begin cls = CLS_R;  dec_fs = FS_AND; end
      OPC_ORR:  begin cls = CLS_R;  dec_fs = FS_ORR; end
      OPC_EOR:  begin cls = CLS_R;  dec_fs = FS_EOR; end
      OPC_LDUR: begin cls = CLS_LD; dec_fs = FS_ADD; end
      OPC_STUR: begin cls = CLS_ST; dec_fs = FS_ADD; end
      default: begin
        case (ir[31:22])
          OPC_ADDI: begin cls = CLS_I; dec_fs = FS_ADD; end
          OPC_SUBI: begin cls = CLS_I; dec_fs = FS_SUB; dec_c0 = 1'b1; end
          default:  cls = CLS_ILL;
        endcase
      end
    endcase
    case (cls)
      CLS_I:          dec_k = {52'd0, ir[21:10]};
      CLS_LD, CLS_ST: dec_k = {{55{ir[20]}}, ir[20:12]};
      default:        dec_k = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = DECODE;
      DECODE:  state_nx = (cls == CLS_ILL) ? IDLE : EXEC;
      EXEC:    state_nx = (cls == CLS_LD || cls == CLS_ST) ? MEM : IDLE;
      MEM:     if (mem_ack) state_nx = (cls == CLS_ST) ? IDLE : WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered with it,
  // so every output is a pure function of the current state and captured word.
  always_comb begin
    ctrl_nx      = '0;
    ctrl_nx.busy = 1'b1;
    case (state_nx)
      IDLE: begin
        ctrl_nx.ready = 1'b1;
        ctrl_nx.busy  = 1'b0;
        // DECODE only falls back to IDLE for an illegal opcode.
        ctrl_nx.err   = (state == DECODE);
      end
      EXEC: begin
        ctrl_nx.fs     = dec_fs;
        ctrl_nx.c0     = dec_c0;
        ctrl_nx.k      = dec_k;
        ctrl_nx.s      = (cls != CLS_R);
        ctrl_nx.addr_a = rn;
        if (cls == CLS_R)       ctrl_nx.addr_b = rm;
        else if (cls == CLS_ST) ctrl_nx.addr_b = rd;
        if (cls == CLS_R || cls == CLS_I) begin
          ctrl_nx.sd     = 1'b1;
          ctrl_nx.addr_r = rd;
          ctrl_nx.w      = (rd != 5'd31);
        end
      end
      MEM: begin
        // Address operands stay on the datapath for the whole access.
        ctrl_nx.fs     = dec_fs;
        ctrl_nx.c0     = dec_c0;
        ctrl_nx.k      = dec_k;
        ctrl_nx.s      = 1'b1;
        ctrl_nx.addr_a = rn;
        if (cls == CLS_ST) begin
          ctrl_nx.mem_we = 1'b1;
          ctrl_nx.sb     = 1'b1;
          ctrl_nx.addr_b = rd;
        end else begin
          ctrl_nx.mem_re = 1'b1;
        end
      end
      WB: begin
        ctrl_nx.addr_r = rd;
        ctrl_nx.w      = (rd != 5'd31);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ir    <= '0;
      ctrl  <= '0;
      flags <= '0;
    end else begin
      state <= state_nx;
      ctrl  <= ctrl_nx;
      if (accept) ir <= instr;
      if (state == EXEC && (cls == CLS_R || cls == CLS_I)) flags <= status;
    end
  end

  assign instr_ready = ctrl.ready;
  assign busy        = ctrl.busy;
  assign err         = ctrl.err;
  assign fs          = ctrl.fs;
  assign c0          = ctrl.c0;
  assign k           = ctrl.k;
  assign s           = ctrl.s;
  assign addrR       = ctrl.addr_r;
  assign addrA       = ctrl.addr_a;
  assign addrB       = ctrl.addr_b;
  assign sb          = ctrl.sb;
  assign sd          = ctrl.sd;
  assign w           = ctrl.w;
  assign mem_re      = ctrl.mem_re;
  assign mem_we      = ctrl.mem_we;

endmodule
